// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter (m0 = data bus, m1 = instruction bus).
// Optional no-ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_reg;
  logic   last_reg;
  logic   gnt0;
  logic   gnt1;
  logic   timeout_hit;

  // Grant is held for the whole cyc tenure; every tenure ends with one IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) state_reg <= last_reg ? GNT0 : GNT1;
          else if (m0_cyc_i)        state_reg <= GNT0;
          else if (m1_cyc_i)        state_reg <= GNT1;
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt0    = (state_reg == GNT0);
  assign gnt1    = (state_reg == GNT1);
  assign grant_o = {gnt1, gnt0};

`ifdef WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             sel_stb;
  logic             sel_cyc;

  assign sel_stb     = (gnt0 && m0_stb_i) || (gnt1 && m1_stb_i);
  assign sel_cyc     = (gnt0 && m0_cyc_i) || (gnt1 && m1_cyc_i);
  assign timeout_hit = sel_stb && !s_ack_i && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!sel_cyc || s_ack_i || timeout_hit) begin
      cnt_reg <= '0;
    end else if (sel_stb) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  // Watchdog parameters have no effect in this build; expression folds to 0.
  assign timeout_hit = (CNT_W == 0) && (TIMEOUT_CYCLES == 0);
`endif

  assign timeout_o = timeout_hit;

  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    if (gnt0) begin
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
      s_sel_o  = m0_sel_i;
      s_we_o   = m0_we_i;
      s_stb_o  = m0_stb_i && !timeout_hit;
      s_cyc_o  = m0_cyc_i;
    end else if (gnt1) begin
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
      s_sel_o  = m1_sel_i;
      s_we_o   = m1_we_i;
      s_stb_o  = m1_stb_i && !timeout_hit;
      s_cyc_o  = m1_cyc_i;
    end
  end

  // A forced ack returns zero data instead of whatever the slave drives.
  assign m0_ack_o  = gnt0 && (s_ack_i || timeout_hit);
  assign m1_ack_o  = gnt1 && (s_ack_i || timeout_hit);
  assign m0_data_o = (gnt0 && !timeout_hit) ? s_data_i : '0;
  assign m1_data_o = (gnt1 && !timeout_hit) ? s_data_i : '0;

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone arbiter placed directly downstream of the core's instruction and data Wishbone master ports. It merges both buses onto the single slave-side bus that feeds the system interconnect. Master 0 is the data bus; master 1 is the instruction bus. Arbitration is round-robin, and each grant is held for the full `cyc` tenure of the granted master.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: no-ack cycles before a forced error ack. Used only with `WB_ARB_TIMEOUT_EN`.
- `CNT_W`, default 9: width of the timeout counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1  single clock for all state.
- `rst`  in  1  asynchronous reset, active-high.
- `m0_addr_i` / `m0_data_i`  in  32/32  data-master address and write data.
- `m0_sel_i`  in  4  byte selects.
- `m0_we_i`, `m0_stb_i`, `m0_cyc_i`  in  1 each  data-master control.
- `m0_data_o`  out  32  read data to data master.
- `m0_ack_o`  out  1  ack to data master.
- `m1_*`  same set as `m0_*`  instruction master.
- `s_addr_o` / `s_data_o`  out  32/32  to slave.
- `s_sel_o`  out  4  byte selects to slave.
- `s_we_o`, `s_stb_o`, `s_cyc_o`  out  1 each  control to slave.
- `s_data_i`  in  32  slave read data.
- `s_ack_i`  in  1  slave ack.
- `grant_o`  out  2  one-hot current grant: `01`=m0, `10`=m1, `00`=idle.
- `timeout_o`  out  1  one-cycle pulse when a forced ack is issued. Tied 0 when the macro is absent.

## Operation
- States: IDLE, GNT0, GNT1. State is registered; `last` is a 1-bit register holding the most recent grantee.
- IDLE:
  - Only `m0_cyc_i` high → GNT0. Only `m1_cyc_i` high → GNT1.
  - Both high → grant the master ≠ `last`.
  - Neither high → stay in IDLE.
- GNTx: stay while `mx_cyc_i` = 1. When `mx_cyc_i` = 0 → IDLE, and `last` ← x.
- After every tenure there is one mandatory IDLE cycle. A master cannot be re-granted back-to-back without passing through IDLE.
- Slave-side outputs are a combinational mux of the granted master's signals. In IDLE all `s_*` outputs are 0.
- Granted master: `mx_ack_o` = `s_ack_i` and `mx_data_o` = `s_data_i`.
- Non-granted master: `ack` = 0 and `data` = 0.
- The arbiter never alters `addr`, `sel`, `we` or data. Multi-beat tenures (`cyc` held across several `stb`/`ack` pairs) pass through unchanged.
- `s_ack_i` arriving in IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE, `last` = 1, so m0 wins the first simultaneous request.
  - `grant_o` = 00, all `s_*` outputs = 0, `m*_ack_o` = 0, `m*_data_o` = 0.
  - `timeout_o` = 0, counter = 0.
- Grant latency: `cyc` sampled high at edge n → GNT state from edge n, so `s_cyc_o`/`s_stb_o` are visible during cycle n+1. Ack return is combinational with 0 added cycles.
- Release: `mx_cyc_i` low at edge n → IDLE in cycle n+1. Earliest new grant is at edge n+1.
- Reset asserted mid-tenure: immediate return to IDLE with all outputs at 0. The slave observes `cyc` dropping, which aborts the cycle.
- The granted master dropping `cyc` in the same cycle that `s_ack_i` = 1: the ack is still passed through in that cycle, then the arbiter goes to IDLE.

## Configuration
Macro: `WB_ARB_TIMEOUT_EN`.

With the macro defined:
- The counter increments each cycle in GNTx while `s_stb_o` = 1 and `s_ack_i` = 0. It clears on `s_ack_i`, on leaving GNTx, and on reset.
- When the counter reaches `TIMEOUT_CYCLES`-1:
  - the arbiter drives `mx_ack_o` = 1 and `mx_data_o` = 0 for one cycle;
  - it forces `s_stb_o` = 0 in that cycle;
  - it pulses `timeout_o`;
  - it clears the counter.

Without the macro:
- There is no counter logic.
- A grant waits indefinitely for `s_ack_i`.
- `timeout_o` = 0.

## Test plan
- Reset release with no requests → `grant_o` = 00 and all `s_*` outputs = 0 for 10 cycles.
- m1 single read, `addr` = 0xBFC00000; slave acks 2 cycles later with 0x3C080001 → `m1_data_o` = 0x3C080001 in the ack cycle, `m0_ack_o` = 0 throughout, and `grant_o` returns to 00 one cycle after `m1_cyc_i` falls.
- m0 and m1 raise `cyc` on the same edge immediately after reset → m0 is granted first. Its write (`addr` 0x80001000, `data` 0xDEADBEEF, `sel` 1111) appears on `s_*`. Then IDLE for one cycle, then m1 is granted.
- Two back-to-back simultaneous-request rounds → grants alternate m0, m1, m0, m1.
- Reset asserted while in GNT1 with `stb` high → `s_cyc_o` = 0 and `grant_o` = 00 immediately, without waiting for a clock edge.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, the slave never acks an m0 read → `m0_ack_o` = 1 with `m0_data_o` = 0 and `timeout_o` = 1 exactly on the 16th stalled cycle. Without the macro, no ack arrives after 100 cycles.
